// File: rtl/m_lsu.sv
// Memory-stage load/store unit: turns M-stage load/store requests into valid/ready bus transactions.
// Optional macro LSU_MISALIGN_TRAP_EN: flag and suppress misaligned accesses instead of force-aligning them.
module m_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_ren_M,
  input  logic              mem_wen_M,
  input  logic [2:0]        funct3_M,
  input  logic [31:0]       alu_result_M,
  input  logic [31:0]       rs2_data_M,
  output logic              stall_M,
  output logic [31:0]       mem_rdata_M,
  output logic              misalign_M,
  output logic              dmem_valid,
  input  logic              dmem_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic [1:0]        o_dbg_state
);

  // Bus handshake: dmem_valid rises in REQ and holds, with every bus output
  // frozen in registers, until the cycle dmem_ready is sampled high; read data
  // is accepted only on dmem_rvalid while waiting in RESP.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_wdata;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [31:0]       r_rdata;

  logic              w_is_store;
  size_t             w_size;
  logic              w_misaligned;
  logic              w_trap;
  logic              w_access;
  logic [1:0]        w_off;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;
  logic [31:0]       w_shift;
  logic [31:0]       w_load;

  // Store wins when both enables are set; stores treat unknown sizes as word.
  assign w_is_store = mem_wen_M;

  always_comb begin
    w_size = SZ_WORD;
    if (w_is_store) begin
      if (funct3_M == 3'b000)      w_size = SZ_BYTE;
      else if (funct3_M == 3'b001) w_size = SZ_HALF;
    end else begin
      case (funct3_M)
        3'b000, 3'b100: w_size = SZ_BYTE;
        3'b001, 3'b101: w_size = SZ_HALF;
        default:        w_size = SZ_WORD;
      endcase
    end
  end

  assign w_misaligned = ((w_size == SZ_HALF) && alu_result_M[0]) ||
                        ((w_size == SZ_WORD) && (alu_result_M[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap     = w_misaligned;
  assign misalign_M = rst_n && (r_state == S_IDLE) && (mem_ren_M || mem_wen_M) && w_misaligned;
`else
  assign w_trap     = 1'b0;
  assign misalign_M = 1'b0;
`endif

  assign w_access = (mem_ren_M || mem_wen_M) && !w_trap;

  always_comb begin
    w_off   = 2'b00;
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    case (w_size)
      SZ_BYTE: begin
        w_off   = alu_result_M[1:0];
        w_wstrb = 4'b0001 << w_off;
        w_wdata = {4{rs2_data_M[7:0]}};
      end
      SZ_HALF: begin
        w_off   = {alu_result_M[1], 1'b0};
        w_wstrb = 4'b0011 << w_off;
        w_wdata = {2{rs2_data_M[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_wstrb = 4'b1111;
        w_wdata = rs2_data_M;
      end
    endcase
    if (!w_is_store) begin
      w_wstrb = 4'b0000;
      w_wdata = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wstrb  <= 4'b0000;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      r_rdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_addr   <= {alu_result_M[ADDR_W-1:2], 2'b00};
            r_we     <= w_is_store;
            r_wstrb  <= w_wstrb;
            r_wdata  <= w_wdata;
            r_funct3 <= funct3_M;
            r_off    <= w_off;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem_ready) r_state <= r_we ? S_DONE : S_RESP;
        end
        S_RESP: begin
          if (dmem_rvalid) begin
            r_rdata <= dmem_rdata;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane select from the latched word, then extend per the load's funct3.
  always_comb begin
    w_shift = r_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_load = {24'h0, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_load = {16'h0, w_shift[15:0]};
      default: w_load = r_rdata;
    endcase
  end

  assign stall_M     = (rst_n && (r_state == S_IDLE) && w_access) ||
                       (r_state == S_REQ) || (r_state == S_RESP);
  assign mem_rdata_M = ((r_state == S_DONE) && !r_we) ? w_load : 32'h0;
  assign dmem_valid  = (r_state == S_REQ);
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign dmem_wstrb  = r_wstrb;
  assign o_dbg_state = r_state;

endmodule
